// File: rtl/fastlock_ctrl_out_monitor.sv
// Fast-lock CTRL_OUT monitor: synchronises the AD936x synth-lock indication,
// measures lock latency after each profile change, and flags timeouts and
// loss of lock. Saturating event counters feed the status registers.
module fastlock_ctrl_out_monitor #(
  parameter int GPIO_W         = 64,
  parameter int LOCK_BIT       = 0,
  parameter int PROFILE_W      = 3,
  parameter int DEBOUNCE       = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LAT_W          = 16,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [GPIO_W-1:0]    gpio_i,
  input  logic [PROFILE_W-1:0] profile_i,
  output logic                 locked_o,
  output logic                 lock_valid_o,
  output logic [PROFILE_W-1:0] lock_profile_o,
  output logic [LAT_W-1:0]     lock_latency_o,
  output logic                 timeout_o,
  output logic                 lost_lock_o,
  output logic [CNT_W-1:0]     lock_count_o,
  output logic [CNT_W-1:0]     timeout_count_o
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [LAT_W:0]   TIMEOUT_L = (LAT_W + 1)'(TIMEOUT_CYCLES);
  localparam logic [LAT_W-1:0] TIMER_MAX = {LAT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    DEBOUNCE_S = 3'd2,
    LOCKED    = 3'd3,
    TIMEOUT   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [PROFILE_W-1:0] profile_q;
  logic [LAT_W-1:0]     timer_q, timer_d;
  logic [DB_W-1:0]      db_q, db_d;
  logic                 locked_q, locked_d;
  logic                 lock_valid_q, lock_valid_d;
  logic [PROFILE_W-1:0] lock_profile_q, lock_profile_d;
  logic [LAT_W-1:0]     lock_latency_q, lock_latency_d;
  logic                 timeout_q, timeout_d;
  logic                 lost_lock_q, lost_lock_d;
  logic [CNT_W-1:0]     lock_count_q, lock_count_d;
  logic [CNT_W-1:0]     timeout_count_q, timeout_count_d;

  logic                 lock_s;
  logic                 change_s;
  logic                 timer_hit_s;
  logic [LAT_W-1:0]     timer_inc_s;

  assign lock_s      = sync2_q;
  assign change_s    = (profile_i != profile_q);
  assign timer_inc_s = (timer_q == TIMER_MAX) ? timer_q : timer_q + LAT_W'(1);
  assign timer_hit_s = (({1'b0, timer_q} + (LAT_W + 1)'(1)) == TIMEOUT_L);

  // Next-state, measurement and counter logic; change detect wins unless disabled.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    db_d            = db_q;
    locked_d        = locked_q;
    lock_valid_d    = 1'b0;
    lock_profile_d  = lock_profile_q;
    lock_latency_d  = lock_latency_q;
    timeout_d       = 1'b0;
    lost_lock_d     = 1'b0;
    lock_count_d    = lock_count_q;
    timeout_count_d = timeout_count_q;

    if (!enable_i) begin
      state_d  = IDLE;
      locked_d = 1'b0;
    end else if (change_s) begin
      state_d  = WAIT_LOCK;
      timer_d  = '0;
      db_d     = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        WAIT_LOCK: begin
          timer_d = timer_inc_s;
          if (timer_hit_s) begin
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
          end else if (lock_s) begin
            state_d = DEBOUNCE_S;
            db_d    = DB_W'(1);
          end else begin
            state_d = WAIT_LOCK;
          end
        end
        DEBOUNCE_S: begin
          timer_d = timer_inc_s;
          if (timer_hit_s) begin
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
          end else if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (db_q == DB_LAST) begin
            state_d        = LOCKED;
            locked_d       = 1'b1;
            lock_valid_d   = 1'b1;
            lock_latency_d = timer_q + LAT_W'(1);
            lock_profile_d = profile_q;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end
        LOCKED: begin
          if (!lock_s) begin
            state_d     = WAIT_LOCK;
            lost_lock_d = 1'b1;
            locked_d    = 1'b0;
            timer_d     = '0;
          end else begin
            state_d = LOCKED;
          end
        end
        TIMEOUT: begin
          state_d = TIMEOUT;
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end

    // Clear dominates any coincident increment; both counters saturate.
    if (clear_i) begin
      lock_count_d    = '0;
      timeout_count_d = '0;
    end else begin
      if (lock_valid_d && (lock_count_q != CNT_MAX)) begin
        lock_count_d = lock_count_q + CNT_W'(1);
      end else begin
        lock_count_d = lock_count_q;
      end
      if (timeout_d && (timeout_count_q != CNT_MAX)) begin
        timeout_count_d = timeout_count_q + CNT_W'(1);
      end else begin
        timeout_count_d = timeout_count_q;
      end
    end
  end

  // State, synchroniser and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      profile_q       <= '0;
      timer_q         <= '0;
      db_q            <= '0;
      locked_q        <= 1'b0;
      lock_valid_q    <= 1'b0;
      lock_profile_q  <= '0;
      lock_latency_q  <= '0;
      timeout_q       <= 1'b0;
      lost_lock_q     <= 1'b0;
      lock_count_q    <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= gpio_i[LOCK_BIT];
      sync2_q         <= sync1_q;
      profile_q       <= profile_i;
      timer_q         <= timer_d;
      db_q            <= db_d;
      locked_q        <= locked_d;
      lock_valid_q    <= lock_valid_d;
      lock_profile_q  <= lock_profile_d;
      lock_latency_q  <= lock_latency_d;
      timeout_q       <= timeout_d;
      lost_lock_q     <= lost_lock_d;
      lock_count_q    <= lock_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign locked_o        = locked_q;
  assign lock_valid_o    = lock_valid_q;
  assign lock_profile_o  = lock_profile_q;
  assign lock_latency_o  = lock_latency_q;
  assign timeout_o       = timeout_q;
  assign lost_lock_o     = lost_lock_q;
  assign lock_count_o    = lock_count_q;
  assign timeout_count_o = timeout_count_q;

endmodule

// File: tb/tb_fastlock_ctrl_out_monitor.sv
// Scoreboard bench for fastlock_ctrl_out_monitor: stimulus pushes expected
// pulse events (kind, edge, profile, latency); a negedge monitor pops them.
module tb_fastlock_ctrl_out_monitor;

  localparam int GPIO_W = 64;
  localparam int PW     = 3;
  localparam int DB     = 4;
  localparam int TO     = 1024;
  localparam int LW     = 16;
  localparam int CW     = 4;
  localparam int CMAX   = 15;

  localparam int EV_LOCK = 1;
  localparam int EV_TO   = 2;
  localparam int EV_LOST = 3;

  typedef struct {
    int kind;
    int cyc;
    int prof;
    int lat;
  } ev_t;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              enable_i = 1'b1;
  logic              clear_i = 1'b0;
  logic [GPIO_W-1:0] gpio_i = '0;
  logic [PW-1:0]     profile_i = '0;
  logic              locked_o, lock_valid_o, timeout_o, lost_lock_o;
  logic [PW-1:0]     lock_profile_o;
  logic [LW-1:0]     lock_latency_o;
  logic [CW-1:0]     lock_count_o, timeout_count_o;

  int  checks = 0;
  int  failures = 0;
  int  edge_cnt = 0;
  ev_t exp_q[$];

  fastlock_ctrl_out_monitor #(
    .GPIO_W(GPIO_W), .LOCK_BIT(0), .PROFILE_W(PW), .DEBOUNCE(DB),
    .TIMEOUT_CYCLES(TO), .LAT_W(LW), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .enable_i(enable_i), .clear_i(clear_i),
    .gpio_i(gpio_i), .profile_i(profile_i), .locked_o(locked_o),
    .lock_valid_o(lock_valid_o), .lock_profile_o(lock_profile_o),
    .lock_latency_o(lock_latency_o), .timeout_o(timeout_o),
    .lost_lock_o(lost_lock_o), .lock_count_o(lock_count_o),
    .timeout_count_o(timeout_count_o)
  );

  always #5 clk = ~clk;

  // Global edge index shared by stimulus and monitor.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after edge e; inputs set next are sampled at edge e+1.
  task automatic wait_until(input int e);
    while (edge_cnt < e) tick(1);
  endtask

  // Lock bit on bit 0; the other GPIO bits carry junk that must be ignored.
  task automatic set_lock(input logic b);
    logic [GPIO_W-1:0] w;
    w = {$urandom(), $urandom()};
    w[0] = b;
    gpio_i = w;
  endtask

  task automatic push(input int kind, input int cyc, input int prof, input int lat);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.prof = prof; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_pulse_kind", kind, 0);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_edge", edge_cnt, e.cyc);
      if (kind == EV_LOCK) begin
        chk("lock_profile", lock_profile_o, e.prof);
        chk("lock_latency", lock_latency_o, e.lat);
      end
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn) begin
      if (lost_lock_o)  pop_cmp(EV_LOST);
      if (lock_valid_o) pop_cmp(EV_LOCK);
      if (timeout_o)    pop_cmp(EV_TO);
    end
  end

  initial begin
    int e0, j, exp_cnt;
    logic [PW-1:0] prof;
    prof = '0;
    exp_cnt = 0;

    // Reset state
    tick(3);
    chk("rst_locked", locked_o, 0);
    chk("rst_valid", lock_valid_o, 0);
    chk("rst_latency", lock_latency_o, 0);
    chk("rst_lock_count", lock_count_o, 0);
    resetn = 1'b1;
    tick(3);

    // Basic lock: profile 0->3 at edge 0, lock raw high from edge 1 -> edge 7, latency 7
    e0 = edge_cnt + 1;
    prof = 3'd3; profile_i = prof;
    push(EV_LOCK, e0 + 7, 3, 7);
    wait_until(e0);
    set_lock(1'b1);
    wait_until(e0 + 10);
    exp_cnt++;
    chk("basic_lock_count", lock_count_o, exp_cnt);
    chk("basic_locked", locked_o, 1);

    // Lost lock: raw low for one edge -> lost pulse 2 edges later, relock latency 5
    j = edge_cnt + 1;
    set_lock(1'b0);
    tick(1);
    set_lock(1'b1);
    push(EV_LOST, j + 2, 0, 0);
    push(EV_LOCK, j + 7, 3, 5);
    wait_until(j + 10);
    exp_cnt++;
    chk("relock_count", lock_count_o, exp_cnt);

    // Glitch: high at edges 1-2, low 3-9, steady from 10 -> lock at edge 16, latency 16
    j = edge_cnt + 1;
    set_lock(1'b0);
    push(EV_LOST, j + 2, 0, 0);
    wait_until(j + 4);
    e0 = edge_cnt + 1;
    prof = 3'd4; profile_i = prof;
    push(EV_LOCK, e0 + 16, 4, 16);
    wait_until(e0);
    set_lock(1'b1);
    wait_until(e0 + 2);
    set_lock(1'b0);
    wait_until(e0 + 9);
    set_lock(1'b1);
    wait_until(e0 + 20);
    exp_cnt++;
    chk("glitch_lock_count", lock_count_o, exp_cnt);

    // Profile change during debounce: old profile never reported, restart from 0
    j = edge_cnt + 1;
    set_lock(1'b0);
    push(EV_LOST, j + 2, 0, 0);
    wait_until(j + 4);
    e0 = edge_cnt + 1;
    prof = 3'd5; profile_i = prof;
    wait_until(e0);
    set_lock(1'b1);
    wait_until(e0 + 4);
    prof = 3'd6; profile_i = prof;
    push(EV_LOCK, e0 + 10, 6, 5);
    wait_until(e0 + 14);
    exp_cnt++;
    chk("restart_lock_count", lock_count_o, exp_cnt);

    // Back-to-back changes with lock held: latency 5 each, counter saturates
    for (int i = 0; i < 12; i++) begin
      e0 = edge_cnt + 1;
      prof = prof + 3'd1; profile_i = prof;
      push(EV_LOCK, e0 + 5, int'(prof), 5);
      wait_until(e0 + 7);
      exp_cnt = (exp_cnt < CMAX) ? exp_cnt + 1 : CMAX;
      if (i >= 9) chk("sat_lock_count", lock_count_o, exp_cnt);
    end
    chk("sat_lock_count_final", lock_count_o, CMAX);

    // clear_i coincident with a lock increment -> 0
    e0 = edge_cnt + 1;
    prof = prof + 3'd1; profile_i = prof;
    push(EV_LOCK, e0 + 5, int'(prof), 5);
    wait_until(e0 + 4);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    wait_until(e0 + 7);
    exp_cnt = 0;
    chk("clear_with_inc", lock_count_o, exp_cnt);

    // Timeout: lock never rises; later lock ignored
    j = edge_cnt + 1;
    set_lock(1'b0);
    push(EV_LOST, j + 2, 0, 0);
    wait_until(j + 4);
    e0 = edge_cnt + 1;
    prof = prof + 3'd1; profile_i = prof;
    push(EV_TO, e0 + TO, 0, 0);
    wait_until(e0 + TO + 6);
    set_lock(1'b1);
    wait_until(e0 + TO + 30);
    chk("timeout_count", timeout_count_o, 1);
    chk("timeout_locked", locked_o, 0);
    chk("timeout_lock_count", lock_count_o, exp_cnt);

    // enable_i low: change ignored, no pulses, counters hold
    enable_i = 1'b0;
    tick(2);
    prof = prof + 3'd1; profile_i = prof;
    tick(12);
    chk("dis_locked", locked_o, 0);
    chk("dis_lock_count", lock_count_o, exp_cnt);
    enable_i = 1'b1;
    tick(12);
    chk("reen_locked", locked_o, 0);
    chk("reen_timeout_count", timeout_count_o, 1);

    // Reset asserted mid-WAIT_LOCK
    set_lock(1'b0);
    tick(4);
    prof = prof + 3'd1; profile_i = prof;
    tick(5);
    resetn = 1'b0;
    #1;
    chk("mid_rst_locked", locked_o, 0);
    chk("mid_rst_valid", lock_valid_o, 0);
    chk("mid_rst_profile", lock_profile_o, 0);
    chk("mid_rst_latency", lock_latency_o, 0);
    chk("mid_rst_timeout", timeout_o, 0);
    chk("mid_rst_lost", lost_lock_o, 0);
    chk("mid_rst_lock_count", lock_count_o, 0);
    chk("mid_rst_timeout_count", timeout_count_o, 0);
    tick(3);
    resetn = 1'b1;
    tick(5);

    chk("scoreboard_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
